// File: rtl/wb_pico_master_bridge_pkg.sv
// ---------------------------------------------------------------------------
// wb_pico_master_bridge_pkg
//   Shared definitions for the picorv32 -> Wishbone pipelined initiator:
//   the bridge FSM state encoding, the all-bytes select constant and a
//   small helper that turns CPU write strobes into Wishbone byte selects.
//   No ports (package).
// ---------------------------------------------------------------------------
package wb_pico_master_bridge_pkg;

    // Bridge FSM: IDLE waits for a CPU request, REQ drives the strobe,
    // WAIT holds cyc for the response, DONE pulses ready to the CPU.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [3:0] WB_SEL_ALL = 4'hF;

    // A zero strobe is a picorv32 read, which always fetches the whole word.
    function automatic logic [3:0] sel_from_wstrb(input logic [3:0] wstrb);
        return (wstrb != 4'h0) ? wstrb : WB_SEL_ALL;
    endfunction

endpackage

// File: rtl/wb_pico_master_bridge_if.sv
// ---------------------------------------------------------------------------
// wb_pico_master_bridge_if
//   Wishbone classic-pipelined bus bundle between the bridge (master) and
//   the slave interconnect (slave).
//   Master drives: cyc, stb, we, addr, dat_w, sel
//   Slave drives : stall, ack, err, dat_r
// ---------------------------------------------------------------------------
interface wb_pico_master_bridge_if;

    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] addr;
    logic [31:0] dat_w;
    logic [3:0]  sel;
    logic        stall;
    logic        ack;
    logic        err;
    logic [31:0] dat_r;

    modport master (
        output cyc, stb, we, addr, dat_w, sel,
        input  stall, ack, err, dat_r
    );

    modport slave (
        input  cyc, stb, we, addr, dat_w, sel,
        output stall, ack, err, dat_r
    );

endinterface

// File: rtl/wb_pico_master_bridge_tmo.sv
// ---------------------------------------------------------------------------
// wb_timeout_counter
//   Saturating cycle counter used by the bridge to abort a bus cycle that
//   never gets an ack or err.
//   i_clk     : clock, rising edge
//   i_reset   : asynchronous active-high reset
//   i_clr     : synchronous clear back to zero (wins over i_en)
//   i_en      : count this cycle
//   o_expired : count has reached MAX-1, i.e. this is the MAX-th counted cycle
// ---------------------------------------------------------------------------
module wb_timeout_counter #(
    parameter int unsigned MAX = 64
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int unsigned W = $clog2(MAX + 1);
    localparam logic [W-1:0] LAST = W'(MAX - 1);
    localparam logic [W-1:0] SAT  = W'(MAX);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear has priority, otherwise count up and stick at MAX
    // so a stuck enable can never wrap back into a fresh window.
    always_comb begin
        count_d = count_q;
        if (i_clr) begin
            count_d = '0;
        end else if (i_en && (count_q != SAT)) begin
            count_d = count_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_expired = (count_q == LAST);

endmodule

// File: rtl/wb_pico_master_bridge.sv
// ---------------------------------------------------------------------------
// wb_pico_master_bridge
//   Wishbone initiator between the picorv32 native memory port and a
//   classic-pipelined Wishbone slave. Each CPU request becomes exactly one
//   Wishbone cycle; the request completes on ack, err or timeout, and the
//   first faulting address is recorded in sticky error flags.
//   i_clk, i_reset            : clock / asynchronous active-high reset
//   i_mem_valid/instr/addr/
//   i_mem_wdata/wstrb         : picorv32 request
//   o_mem_ready/o_mem_rdata   : one-cycle completion pulse and read data
//   wb (master modport)       : Wishbone bus
//   i_err_clr                 : clears the sticky error flags
//   o_bus_err/_tmo/_instr/_addr : sticky error status and first fault info
// ---------------------------------------------------------------------------
module wb_pico_master_bridge
    import wb_pico_master_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_mem_valid,
    input  logic                     i_mem_instr,
    input  logic [31:0]              i_mem_addr,
    input  logic [31:0]              i_mem_wdata,
    input  logic [3:0]               i_mem_wstrb,
    output logic                     o_mem_ready,
    output logic [31:0]              o_mem_rdata,
    wb_pico_master_bridge_if.master  wb,
    input  logic                     i_err_clr,
    output logic                     o_bus_err,
    output logic                     o_bus_err_tmo,
    output logic                     o_bus_err_instr,
    output logic [31:0]              o_bus_err_addr
);

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  sel_q, sel_d;
    logic        we_q, we_d;
    logic        instr_q, instr_d;
    logic        cyc_q, cyc_d;
    logic        stb_q, stb_d;
    logic        ready_q, ready_d;
    logic [31:0] rdata_q, rdata_d;
    logic        busErr_q, busErr_d;
    logic        busErrTmo_q, busErrTmo_d;
    logic        errInstr_q, errInstr_d;
    logic [31:0] errAddr_q, errAddr_d;

    logic        tmoClr;
    logic        tmoExpired;
    logic        doneAck;
    logic        doneErr;
    logic        doneTmo;

    // The timeout window opens on IDLE->REQ and counts every cycle cyc is up.
    wb_timeout_counter #(
        .MAX (TIMEOUT_CYCLES)
    ) u_tmo (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_clr     (tmoClr),
        .i_en      (cyc_q),
        .o_expired (tmoExpired)
    );

    // Next-state and next-output logic. Every output is a register, so the
    // values computed here appear on the pins one cycle later. Completion
    // priority is err, then ack, then timeout; the error flags are handled
    // after the FSM so clear and a fresh error in one cycle keep the error.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        sel_d       = sel_q;
        we_d        = we_q;
        instr_d     = instr_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        ready_d     = 1'b0;
        rdata_d     = rdata_q;
        busErr_d    = busErr_q;
        busErrTmo_d = busErrTmo_q;
        errInstr_d  = errInstr_q;
        errAddr_d   = errAddr_q;
        tmoClr      = 1'b0;
        doneAck     = 1'b0;
        doneErr     = 1'b0;
        doneTmo     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_mem_valid) begin
                    addr_d  = i_mem_addr;
                    wdata_d = i_mem_wdata;
                    sel_d   = sel_from_wstrb(i_mem_wstrb);
                    we_d    = (i_mem_wstrb != 4'h0);
                    instr_d = i_mem_instr;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    tmoClr  = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ, ST_WAIT: begin
                if (wb.err) begin
                    doneErr = 1'b1;
                end else if (wb.ack) begin
                    doneAck = 1'b1;
                end else if (tmoExpired) begin
                    doneTmo = 1'b1;
                end

                if (doneErr || doneAck || doneTmo) begin
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    ready_d = 1'b1;
                    state_d = ST_DONE;
                end else if ((state_q == ST_REQ) && !wb.stall) begin
                    stb_d   = 1'b0;
                    state_d = ST_WAIT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (doneErr || doneTmo) begin
            rdata_d = ERR_RDATA;
        end else if (doneAck) begin
            rdata_d = we_q ? 32'h0 : wb.dat_r;
        end

        if (i_err_clr) begin
            busErr_d    = 1'b0;
            busErrTmo_d = 1'b0;
        end
        if (doneErr || doneTmo) begin
            if (!busErr_q || i_err_clr) begin
                errAddr_d  = addr_q;
                errInstr_d = instr_q;
            end
            busErr_d = 1'b1;
            if (doneTmo) begin
                busErrTmo_d = 1'b1;
            end
        end
    end

    // State and output registers; reset drops cyc/stb immediately.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            sel_q       <= '0;
            we_q        <= 1'b0;
            instr_q     <= 1'b0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            ready_q     <= 1'b0;
            rdata_q     <= '0;
            busErr_q    <= 1'b0;
            busErrTmo_q <= 1'b0;
            errInstr_q  <= 1'b0;
            errAddr_q   <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            sel_q       <= sel_d;
            we_q        <= we_d;
            instr_q     <= instr_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            ready_q     <= ready_d;
            rdata_q     <= rdata_d;
            busErr_q    <= busErr_d;
            busErrTmo_q <= busErrTmo_d;
            errInstr_q  <= errInstr_d;
            errAddr_q   <= errAddr_d;
        end
    end

    assign wb.cyc          = cyc_q;
    assign wb.stb          = stb_q;
    assign wb.we           = we_q;
    assign wb.addr         = addr_q;
    assign wb.dat_w        = wdata_q;
    assign wb.sel          = sel_q;
    assign o_mem_ready     = ready_q;
    assign o_mem_rdata     = rdata_q;
    assign o_bus_err       = busErr_q;
    assign o_bus_err_tmo   = busErrTmo_q;
    assign o_bus_err_instr = errInstr_q;
    assign o_bus_err_addr  = errAddr_q;

endmodule

// File: tb/tb_wb_pico_master_bridge.sv
// ---------------------------------------------------------------------------
// tb_wb_pico_master_bridge
//   Directed bench for the picorv32 -> Wishbone bridge, built with an
//   8-cycle timeout. A table of request/slave-behaviour records with
//   hand-computed results drives most traffic; reset-in-WAIT, stray ack in
//   IDLE and back-to-back issue are written out by hand.
// ---------------------------------------------------------------------------
module tb_wb_pico_master_bridge;

    localparam int unsigned TMO = 8;

    localparam int RESP_ACK  = 0;
    localparam int RESP_ERR  = 1;
    localparam int RESP_BOTH = 2;
    localparam int RESP_NONE = 3;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        instr;
        int          stallCycles;
        int          ackDelay;
        int          resp;
        logic [31:0] slvData;
        logic        clrBefore;
        logic        clrAtResp;
        logic        dropValid;
        logic [31:0] expRdata;
        logic        expWe;
        logic [3:0]  expSel;
        int          expStb;
        int          expCyc;
        logic        expBusErr;
        logic        expTmo;
        logic [31:0] expErrAddr;
        logic        expErrInstr;
    } vector_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        memValid;
    logic        memInstr;
    logic [31:0] memAddr;
    logic [31:0] memWdata;
    logic [3:0]  memWstrb;
    logic        memReady;
    logic [31:0] memRdata;
    logic        errClr;
    logic        busErr;
    logic        busErrTmo;
    logic        busErrInstr;
    logic [31:0] busErrAddr;

    int vectorsApplied = 0;
    int miscompares    = 0;

    vector_t vecs[11];

    wb_pico_master_bridge_if wbIf();

    wb_pico_master_bridge #(
        .TIMEOUT_CYCLES (TMO),
        .ERR_RDATA      (32'hDEAD_BEEF)
    ) dut (
        .i_clk           (clock),
        .i_reset         (reset),
        .i_mem_valid     (memValid),
        .i_mem_instr     (memInstr),
        .i_mem_addr      (memAddr),
        .i_mem_wdata     (memWdata),
        .i_mem_wstrb     (memWstrb),
        .o_mem_ready     (memReady),
        .o_mem_rdata     (memRdata),
        .wb              (wbIf),
        .i_err_clr       (errClr),
        .o_bus_err       (busErr),
        .o_bus_err_tmo   (busErrTmo),
        .o_bus_err_instr (busErrInstr),
        .o_bus_err_addr  (busErrAddr)
    );

    // 100 MHz-style free-running clock.
    always #5 clock = ~clock;

    // Hard stop in case something upstream loops forever.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, required finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectorsApplied++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    function automatic vector_t mkVec(
        input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
        input logic instr, input int stallCycles, input int ackDelay, input int resp,
        input logic [31:0] slvData, input logic clrBefore, input logic clrAtResp,
        input logic dropValid, input logic [31:0] expRdata, input logic expWe,
        input logic [3:0] expSel, input int expStb, input int expCyc,
        input logic expBusErr, input logic expTmo, input logic [31:0] expErrAddr,
        input logic expErrInstr);
        vector_t v;
        v.addr = addr;             v.wdata = wdata;           v.wstrb = wstrb;
        v.instr = instr;           v.stallCycles = stallCycles; v.ackDelay = ackDelay;
        v.resp = resp;             v.slvData = slvData;       v.clrBefore = clrBefore;
        v.clrAtResp = clrAtResp;   v.dropValid = dropValid;   v.expRdata = expRdata;
        v.expWe = expWe;           v.expSel = expSel;         v.expStb = expStb;
        v.expCyc = expCyc;         v.expBusErr = expBusErr;   v.expTmo = expTmo;
        v.expErrAddr = expErrAddr; v.expErrInstr = expErrInstr;
        return v;
    endfunction

    // Issues one CPU request from IDLE, plays the slave as the record says,
    // and checks the bus cycle, the completion pulse and the error flags.
    task automatic applyStimulus(input vector_t v, input string tag);
        int          stbCount  = 0;
        int          cycCount  = 0;
        int          acceptIdx = -1;
        logic        stable    = 1'b1;
        logic        sawReady  = 1'b0;
        logic [31:0] gotRdata  = 32'h0;

        if (v.clrBefore) begin
            errClr = 1'b1;
            @(posedge clock); #1;
            errClr = 1'b0;
        end

        memValid = 1'b1;
        memInstr = v.instr;
        memAddr  = v.addr;
        memWdata = v.wdata;
        memWstrb = v.wstrb;
        @(posedge clock); #1;
        checkOutput({tag, "_stb_latency"}, 32'(wbIf.stb), 32'd1);
        checkOutput({tag, "_we"}, 32'(wbIf.we), 32'(v.expWe));
        checkOutput({tag, "_sel"}, 32'(wbIf.sel), 32'(v.expSel));
        checkOutput({tag, "_addr"}, wbIf.addr, v.addr);
        if (v.expWe) checkOutput({tag, "_wdata"}, wbIf.dat_w, v.wdata);
        if (v.dropValid) memValid = 1'b0;

        for (int k = 0; k < 40 && !sawReady; k++) begin
            if (memReady) begin
                sawReady    = 1'b1;
                gotRdata    = memRdata;
                wbIf.ack    = 1'b0;
                wbIf.err    = 1'b0;
                wbIf.stall  = 1'b0;
                wbIf.dat_r  = 32'h0;
                memValid    = 1'b0;
                errClr      = 1'b0;
            end else begin
                if (wbIf.cyc) cycCount++;
                if (wbIf.stb) begin
                    stbCount++;
                    if (wbIf.addr !== v.addr || wbIf.dat_w !== v.wdata ||
                        wbIf.sel !== v.expSel || wbIf.we !== v.expWe) stable = 1'b0;
                end
                wbIf.stall = wbIf.stb && (stbCount <= v.stallCycles);
                if (wbIf.stb && !wbIf.stall && acceptIdx < 0) acceptIdx = k;
                wbIf.ack   = 1'b0;
                wbIf.err   = 1'b0;
                wbIf.dat_r = 32'h0;
                if (acceptIdx >= 0 && k == acceptIdx + v.ackDelay && v.resp != RESP_NONE) begin
                    wbIf.ack   = (v.resp == RESP_ACK) || (v.resp == RESP_BOTH);
                    wbIf.err   = (v.resp == RESP_ERR) || (v.resp == RESP_BOTH);
                    wbIf.dat_r = v.slvData;
                    if (v.clrAtResp) errClr = 1'b1;
                end
                @(posedge clock); #1;
            end
        end

        checkOutput({tag, "_ready_seen"}, 32'(sawReady), 32'd1);
        if (!sawReady) begin
            wbIf.ack = 1'b0; wbIf.err = 1'b0; wbIf.stall = 1'b0;
            memValid = 1'b0; errClr = 1'b0;
        end
        checkOutput({tag, "_rdata"}, gotRdata, v.expRdata);
        checkOutput({tag, "_stb_cycles"}, 32'(stbCount), 32'(v.expStb));
        checkOutput({tag, "_cyc_cycles"}, 32'(cycCount), 32'(v.expCyc));
        checkOutput({tag, "_stable"}, 32'(stable), 32'd1);

        @(posedge clock); #1;
        checkOutput({tag, "_ready_width"}, 32'(memReady), 32'd0);
        checkOutput({tag, "_cyc_after"}, 32'(wbIf.cyc), 32'd0);
        checkOutput({tag, "_bus_err"}, 32'(busErr), 32'(v.expBusErr));
        checkOutput({tag, "_bus_err_tmo"}, 32'(busErrTmo), 32'(v.expTmo));
        checkOutput({tag, "_err_addr"}, busErrAddr, v.expErrAddr);
        checkOutput({tag, "_err_instr"}, 32'(busErrInstr), 32'(v.expErrInstr));
    endtask

    // Main sequence: reset checks, table vectors, then the hand sequences.
    initial begin
        int          stbCount;
        int          readyCount;
        logic [31:0] lastAddr;
        vector_t     postReset;

        //               addr          wdata         wstrb  in stl dly resp       slvData       cB   cR   dV   expRdata      we   sel   stb cyc bErr tmo  errAddr       eIn
        vecs[0]  = mkVec(32'h8000_0010, 32'h0,        4'h0, 0, 0, 2, RESP_ACK,  32'h1234_5678, 1'b0,1'b0,1'b0, 32'h1234_5678,1'b0,4'hF, 1, 3, 1'b0,1'b0,32'h0,         1'b0);
        vecs[1]  = mkVec(32'h8000_0000, 32'h0000_003F,4'h1, 0, 3, 0, RESP_ACK,  32'hAAAA_5555, 1'b0,1'b0,1'b0, 32'h0,        1'b1,4'h1, 4, 4, 1'b0,1'b0,32'h0,         1'b0);
        vecs[2]  = mkVec(32'h8000_0004, 32'hCAFE_F00D,4'hF, 0, 1, 1, RESP_ACK,  32'h5555_AAAA, 1'b0,1'b0,1'b1, 32'h0,        1'b1,4'hF, 2, 3, 1'b0,1'b0,32'h0,         1'b0);
        vecs[3]  = mkVec(32'h8000_0008, 32'h1122_3344,4'hC, 0, 0, 0, RESP_ACK,  32'h0F0F_0F0F, 1'b0,1'b0,1'b0, 32'h0,        1'b1,4'hC, 1, 1, 1'b0,1'b0,32'h0,         1'b0);
        vecs[4]  = mkVec(32'h9000_0000, 32'h0,        4'h0, 1, 0, 1, RESP_ERR,  32'h1111_1111, 1'b0,1'b0,1'b0, 32'hDEAD_BEEF,1'b0,4'hF, 1, 2, 1'b1,1'b0,32'h9000_0000, 1'b1);
        vecs[5]  = mkVec(32'h9000_0004, 32'h0000_00AA,4'hF, 0, 0, 0, RESP_ERR,  32'h2222_2222, 1'b0,1'b0,1'b0, 32'hDEAD_BEEF,1'b1,4'hF, 1, 1, 1'b1,1'b0,32'h9000_0000, 1'b1);
        vecs[6]  = mkVec(32'h9000_0008, 32'h0,        4'h0, 0, 0, 0, RESP_BOTH, 32'h0000_5A5A, 1'b1,1'b0,1'b0, 32'hDEAD_BEEF,1'b0,4'hF, 1, 1, 1'b1,1'b0,32'h9000_0008, 1'b0);
        vecs[7]  = mkVec(32'hA000_0000, 32'h0,        4'h0, 1, 0, 0, RESP_NONE, 32'h0,         1'b1,1'b0,1'b0, 32'hDEAD_BEEF,1'b0,4'hF, 1, 8, 1'b1,1'b1,32'hA000_0000, 1'b1);
        vecs[8]  = mkVec(32'h8000_0020, 32'h0,        4'h0, 0, 0, 0, RESP_ACK,  32'h0BAD_CAFE, 1'b1,1'b0,1'b0, 32'h0BAD_CAFE,1'b0,4'hF, 1, 1, 1'b0,1'b0,32'hA000_0000, 1'b1);
        vecs[9]  = mkVec(32'hB000_0000, 32'h0,        4'h0, 0, 20,0, RESP_NONE, 32'h0,         1'b0,1'b0,1'b0, 32'hDEAD_BEEF,1'b0,4'hF, 8, 8, 1'b1,1'b1,32'hB000_0000, 1'b0);
        vecs[10] = mkVec(32'hC000_0000, 32'h00AB_CD00,4'h6, 1, 0, 1, RESP_ERR,  32'h3333_3333, 1'b0,1'b1,1'b0, 32'hDEAD_BEEF,1'b1,4'h6, 1, 2, 1'b1,1'b0,32'hC000_0000, 1'b1);

        reset      = 1'b1;
        memValid   = 1'b0;
        memInstr   = 1'b0;
        memAddr    = 32'h0;
        memWdata   = 32'h0;
        memWstrb   = 4'h0;
        errClr     = 1'b0;
        wbIf.stall = 1'b0;
        wbIf.ack   = 1'b0;
        wbIf.err   = 1'b0;
        wbIf.dat_r = 32'h0;

        repeat (3) @(posedge clock);
        #1;
        checkOutput("reset_cyc", 32'(wbIf.cyc), 32'd0);
        checkOutput("reset_stb", 32'(wbIf.stb), 32'd0);
        checkOutput("reset_ready", 32'(memReady), 32'd0);
        checkOutput("reset_rdata", memRdata, 32'h0);
        checkOutput("reset_sel", 32'(wbIf.sel), 32'd0);
        checkOutput("reset_bus_err", 32'(busErr), 32'd0);
        checkOutput("reset_err_addr", busErrAddr, 32'h0);
        reset = 1'b0;
        @(posedge clock); #1;

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset while the bridge sits in WAIT: cyc must fall without a clock.
        memValid = 1'b1;
        memAddr  = 32'h8000_0040;
        memWstrb = 4'h0;
        @(posedge clock); #1;
        memValid = 1'b0;
        @(posedge clock); #1;
        checkOutput("wait_cyc_before_reset", 32'(wbIf.cyc), 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("async_reset_cyc", 32'(wbIf.cyc), 32'd0);
        checkOutput("async_reset_stb", 32'(wbIf.stb), 32'd0);
        checkOutput("async_reset_ready", 32'(memReady), 32'd0);
        checkOutput("async_reset_bus_err", 32'(busErr), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        postReset = mkVec(32'h8000_0044, 32'h0, 4'h0, 0, 0, 0, RESP_ACK, 32'h7777_0001,
                          1'b0, 1'b0, 1'b0, 32'h7777_0001, 1'b0, 4'hF, 1, 1,
                          1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(postReset, "post_reset");

        // A stray ack/err while IDLE must not complete anything.
        wbIf.ack = 1'b1;
        wbIf.err = 1'b1;
        @(posedge clock); #1;
        wbIf.ack = 1'b0;
        wbIf.err = 1'b0;
        checkOutput("idle_ack_ready", 32'(memReady), 32'd0);
        checkOutput("idle_err_flag", 32'(busErr), 32'd0);
        @(posedge clock); #1;
        checkOutput("idle_ack_ready_late", 32'(memReady), 32'd0);

        // Back-to-back: valid stays high through DONE while the CPU moves on
        // to its next address; exactly two bus cycles must result.
        stbCount   = 0;
        readyCount = 0;
        lastAddr   = 32'h0;
        memValid   = 1'b1;
        memAddr    = 32'h8000_0100;
        memWstrb   = 4'h0;
        for (int k = 0; k < 20; k++) begin
            if (memReady) begin
                readyCount++;
                if (readyCount == 1) memAddr = 32'h8000_0104;
                else memValid = 1'b0;
            end
            if (wbIf.stb) begin
                stbCount++;
                lastAddr   = wbIf.addr;
                wbIf.ack   = 1'b1;
                wbIf.dat_r = 32'h4242_0000;
            end else begin
                wbIf.ack   = 1'b0;
                wbIf.dat_r = 32'h0;
            end
            @(posedge clock); #1;
        end
        memValid = 1'b0;
        wbIf.ack = 1'b0;
        checkOutput("b2b_stb_count", 32'(stbCount), 32'd2);
        checkOutput("b2b_ready_count", 32'(readyCount), 32'd2);
        checkOutput("b2b_second_addr", lastAddr, 32'h8000_0104);

        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule
